// File: rtl/tiq_therm_if.sv
// Sample/result bundle between the comparator back end and the thermometer encoder.
// The master drives sample-enable, the raw thermometer word and flag clear; the slave returns results.
interface tiq_therm_if #(
    parameter int N_BITS   = 3,
    parameter int AVG_LOG2 = 0
);
    localparam int THERM_W = (1 << N_BITS) - 1;
    localparam int OUT_W   = N_BITS + AVG_LOG2;

    logic               en;
    logic [THERM_W-1:0] therm_in;
    logic               clr_flags;
    logic [OUT_W-1:0]   code_out;
    logic               code_valid;
    logic               over_rng;
    logic               under_rng;
    logic               bubble_err;

    modport master (
        output en, therm_in, clr_flags,
        input  code_out, code_valid, over_rng, under_rng, bubble_err
    );

    modport slave (
        input  en, therm_in, clr_flags,
        output code_out, code_valid, over_rng, under_rng, bubble_err
    );
endinterface

// File: rtl/tiq_therm_encoder.sv
// Thermometer-to-binary encoder: 2-flop synchroniser, bubble-aware encode register,
// optional 2**AVG_LOG2 sample accumulation with a one-cycle result strobe.
module tiq_therm_encoder #(
    parameter int N_BITS      = 3,
    parameter int BUBBLE_MODE = 0,
    parameter int AVG_LOG2    = 0
) (
    input logic       clk,
    input logic       rst_n,
    tiq_therm_if.slave bus
);
    localparam int THERM_W = (1 << N_BITS) - 1;
    localparam int OUT_W   = N_BITS + AVG_LOG2;
    localparam int CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    function automatic logic [N_BITS-1:0] ones_count(input logic [THERM_W-1:0] t);
        logic [N_BITS-1:0] c;
        c = '0;
        for (int i = 0; i < THERM_W; i++) c = c + N_BITS'(t[i]);
        return c;
    endfunction

    // Boundary bits model an always-tripped comparator below 0 and a never-tripped one above the top.
    function automatic logic [N_BITS-1:0] maj_priority(input logic [THERM_W-1:0] t);
        logic [THERM_W+1:0] ext;
        logic [N_BITS-1:0]  c;
        logic               a, b, d;
        ext = {1'b0, t, 1'b1};
        c   = '0;
        for (int i = 0; i < THERM_W; i++) begin
            a = ext[i];
            b = ext[i+1];
            d = ext[i+2];
            if ((a & b) | (a & d) | (b & d)) c = N_BITS'(i + 1);
        end
        return c;
    endfunction

    function automatic logic non_monotone(input logic [THERM_W-1:0] t);
        return |(t & (t + THERM_W'(1)));
    endfunction

    logic [THERM_W-1:0] sync_p0, sync_p1;
    logic               vld_p0, vld_p1, vld_p2;
    logic [N_BITS-1:0]  code_p2;
    logic               full_p2, zero_p2, bubble_p2;
    logic [N_BITS-1:0]  enc_code;

    logic [CNT_W-1:0]   cnt;
    logic [OUT_W-1:0]   acc;
    logic               hi, lo;
    logic               win_last;

    logic [OUT_W-1:0]   code_out_p3;
    logic               code_valid_p3, over_rng_p3, under_rng_p3, bubble_err_p3;

    always_comb begin
        enc_code = (BUBBLE_MODE == 1) ? maj_priority(sync_p1) : ones_count(sync_p1);
        win_last = (AVG_LOG2 == 0) || (cnt == '1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0       <= '0;
            sync_p1       <= '0;
            vld_p0        <= 1'b0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            code_p2       <= '0;
            full_p2       <= 1'b0;
            zero_p2       <= 1'b0;
            bubble_p2     <= 1'b0;
            cnt           <= '0;
            acc           <= '0;
            hi            <= 1'b0;
            lo            <= 1'b0;
            code_out_p3   <= '0;
            code_valid_p3 <= 1'b0;
            over_rng_p3   <= 1'b0;
            under_rng_p3  <= 1'b0;
            bubble_err_p3 <= 1'b0;
        end else begin
            // S1/S2: synchroniser, enable follows in lock-step
            sync_p0 <= bus.therm_in;
            sync_p1 <= sync_p0;
            vld_p0  <= bus.en;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;

            // S3: encode register, flags taken on the uncorrected word
            code_p2   <= enc_code;
            full_p2   <= &sync_p1;
            zero_p2   <= ~|sync_p1;
            bubble_p2 <= non_monotone(sync_p1);

            // S4: flags, accumulation and output strobe
            if (bus.clr_flags)        bubble_err_p3 <= 1'b0;
            if (vld_p2 && bubble_p2)  bubble_err_p3 <= 1'b1;

            code_valid_p3 <= 1'b0;
            if (vld_p2) begin
                if (win_last) begin
                    code_out_p3   <= acc + OUT_W'(code_p2);
                    over_rng_p3   <= hi | full_p2;
                    under_rng_p3  <= lo | zero_p2;
                    code_valid_p3 <= 1'b1;
                    acc           <= '0;
                    cnt           <= '0;
                    hi            <= 1'b0;
                    lo            <= 1'b0;
                end else begin
                    acc <= acc + OUT_W'(code_p2);
                    cnt <= cnt + CNT_W'(1);
                    hi  <= hi | full_p2;
                    lo  <= lo | zero_p2;
                end
            end
        end
    end

    assign bus.code_out   = code_out_p3;
    assign bus.code_valid = code_valid_p3;
    assign bus.over_rng   = over_rng_p3;
    assign bus.under_rng  = under_rng_p3;
    assign bus.bubble_err = bubble_err_p3;
endmodule
